host_mem_loader: RTL and testbench

HOST_MEM_LOADER -- requirements
Module: host_mem_loader

---
 rtl/host_mem_loader.sv | 92 +++++++++
 tb/tb_host_mem_loader.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_mem_loader.sv
// Host-to-unified-memory loader: a header word sets base address and word count,
// then payload words are written one per cycle with a single registered write stage.
module host_mem_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] host_data,
  input  logic                  host_valid,
  output logic                  host_ready,
  input  logic                  core_busy,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  load_done,
  output logic                  hdr_err,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_cnt;
  logic [6:0]            remain_cnt;
  logic                  accept;

  // A header is usable only with the magic byte and a count of 1..64 words.
  function automatic logic hdr_ok(input logic [DATA_WIDTH-1:0] w);
    logic [6:0] cnt;
    cnt = w[6:0];
    return (w[31:24] == 8'hA5) && (cnt != 7'd0) && (cnt <= 7'd64);
  endfunction

  assign host_ready = !reset && !core_busy && (state != DONE);
  assign accept     = host_valid && host_ready;

  // Stage p1: registered memory write, status pulses and control state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      addr_cnt    <= '0;
      remain_cnt  <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      load_done   <= 1'b0;
      hdr_err     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      mem_wr_en <= 1'b0;
      load_done <= 1'b0;
      hdr_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (hdr_ok(host_data)) begin
              addr_cnt   <= host_data[16 +: ADDR_WIDTH];
              remain_cnt <= host_data[6:0];
              busy       <= 1'b1;
              state      <= LOAD;
            end else begin
              hdr_err <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            mem_wr_en   <= 1'b1;
            mem_wr_addr <= addr_cnt;
            mem_wr_data <= host_data;
            addr_cnt    <= addr_cnt + 1'b1;
            remain_cnt  <= remain_cnt - 7'd1;
            if (remain_cnt == 7'd1) begin
              load_done <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_host_mem_loader.sv
// Randomized bench for host_mem_loader; expected writes come from a stream-level
// model that parses the accepted host words into (address, data, last) records.
module tb_host_mem_loader;

  logic        clk;
  logic        reset;
  logic [31:0] host_data;
  logic        host_valid;
  logic        host_ready;
  logic        core_busy;
  logic        mem_wr_en;
  logic [5:0]  mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        load_done;
  logic        hdr_err;
  logic        busy;

  host_mem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) dut (
    .clk(clk), .reset(reset), .host_data(host_data), .host_valid(host_valid),
    .host_ready(host_ready), .core_busy(core_busy), .mem_wr_en(mem_wr_en),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .load_done(load_done),
    .hdr_err(hdr_err), .busy(busy)
  );

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
    logic        done;
    int          cyc;
  } wr_t;

  wr_t  wr_q[$];
  wr_t  exp_q[$];
  int   hdr_cnt, exp_hdr, done_cnt, stray_done;
  logic busy_after_done;
  logic prev_done;
  int   cyc;
  int   checks, passed;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_wr_en) wr_q.push_back('{addr: mem_wr_addr, data: mem_wr_data, done: load_done, cyc: cyc});
    if (hdr_err) hdr_cnt++;
    if (load_done) begin
      done_cnt++;
      if (!mem_wr_en) stray_done++;
    end
    if (prev_done) busy_after_done = busy;
    prev_done = load_done;
  end

  // Reference: parse a word stream starting from "expecting header".
  function automatic void model(input logic [31:0] w[$]);
    int i, cnt, base;
    logic [31:0] h;
    i = 0;
    while (i < w.size()) begin
      h = w[i];
      i++;
      cnt  = int'(h[6:0]);
      base = int'(h[21:16]);
      if (h[31:24] != 8'hA5 || cnt < 1 || cnt > 64) begin
        exp_hdr++;
        continue;
      end
      for (int k = 0; k < cnt && i < w.size(); k++) begin
        exp_q.push_back('{addr: 6'((base + k) % 64), data: w[i], done: 1'(k == cnt - 1), cyc: 0});
        i++;
      end
    end
  endfunction

  task automatic send(input logic [31:0] w, input int busy_pct, input int gap_pct);
    int tries;
    bit ok;
    tries = 0;
    ok = 0;
    while (!ok) begin
      @(negedge clk);
      host_data  = w;
      host_valid = ($urandom_range(99) >= gap_pct);
      core_busy  = ($urandom_range(99) < busy_pct);
      #1;
      if (host_valid && host_ready) ok = 1;
      else if (++tries > 300) begin
        checks++;
        $display("FAIL send_timeout word=%h ready=%b busy=%b", w, host_ready, busy);
        return;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      host_valid = 1'b0;
      core_busy  = 1'b0;
    end
  endtask

  task automatic clear();
    @(negedge clk);
    #2;
    wr_q.delete();
    exp_q.delete();
    hdr_cnt = 0; exp_hdr = 0; done_cnt = 0; stray_done = 0;
    busy_after_done = 1'bx;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    host_valid = 1'b1; host_data = 32'hA500_0004; core_busy = 1'b0;
    #1;
    checks++; if (host_ready !== 1'b0) $display("FAIL rst_ready got %b exp 0", host_ready); else passed++;
    checks++; if (mem_wr_en !== 1'b0) $display("FAIL rst_wr_en got %b exp 0", mem_wr_en); else passed++;
    checks++; if (load_done !== 1'b0) $display("FAIL rst_done got %b exp 0", load_done); else passed++;
    checks++; if (hdr_err !== 1'b0) $display("FAIL rst_hdr_err got %b exp 0", hdr_err); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else passed++;
    checks++; if (mem_wr_addr !== 6'd0) $display("FAIL rst_addr got %0d exp 0", mem_wr_addr); else passed++;
    checks++; if (mem_wr_data !== 32'd0) $display("FAIL rst_data got %h exp 0", mem_wr_data); else passed++;
    @(negedge clk);
    host_valid = 1'b0; reset = 1'b0;
    #1;
    checks++; if (host_ready !== 1'b1) $display("FAIL idle_ready got %b exp 1", host_ready); else passed++;
    core_busy = 1'b1;
    #1;
    checks++; if (host_ready !== 1'b0) $display("FAIL idle_ready_corebusy got %b exp 0", host_ready); else passed++;
    core_busy = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] ws[$];
    clear();
    ws = '{32'hA500_0004, 32'd1, 32'd2, 32'd3, 32'd4};
    foreach (ws[i]) send(ws[i], 0, 0);
    idle(4);
    model(ws);
    checks++; if (wr_q.size() !== exp_q.size()) $display("FAIL b2b_count got %0d exp %0d", wr_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[i].addr !== exp_q[i].addr || wr_q[i].data !== exp_q[i].data || wr_q[i].done !== exp_q[i].done)
        $display("FAIL b2b_write[%0d] got a=%0d d=%h last=%b exp a=%0d d=%h last=%b", i,
                 wr_q[i].addr, wr_q[i].data, wr_q[i].done, exp_q[i].addr, exp_q[i].data, exp_q[i].done);
      else passed++;
      if (i > 0) begin
        checks++;
        if (wr_q[i].cyc !== wr_q[0].cyc + i) $display("FAIL b2b_cycle[%0d] got %0d exp %0d", i, wr_q[i].cyc, wr_q[0].cyc + i);
        else passed++;
      end
    end
    checks++; if (busy_after_done !== 1'b0) $display("FAIL b2b_busy_fall got %b exp 0", busy_after_done); else passed++;
    checks++; if (done_cnt !== 1 || stray_done !== 0) $display("FAIL b2b_done got %0d/%0d exp 1/0", done_cnt, stray_done); else passed++;
  endtask

  task automatic test_wrap_and_bad_header();
    logic [31:0] ws[$];
    clear();
    ws = '{32'hA53E_0004, $urandom, $urandom, $urandom, $urandom,
           32'h1200_0004, 32'hA500_0000, 32'hA500_0041, 32'hA5C5_FF82, $urandom, $urandom};
    foreach (ws[i]) send(ws[i], 20, 20);
    idle(4);
    model(ws);
    checks++; if (wr_q.size() !== exp_q.size()) $display("FAIL wrap_count got %0d exp %0d", wr_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[i].addr !== exp_q[i].addr || wr_q[i].data !== exp_q[i].data || wr_q[i].done !== exp_q[i].done)
        $display("FAIL wrap_write[%0d] got a=%0d d=%h last=%b exp a=%0d d=%h last=%b", i,
                 wr_q[i].addr, wr_q[i].data, wr_q[i].done, exp_q[i].addr, exp_q[i].data, exp_q[i].done);
      else passed++;
    end
    checks++; if (hdr_cnt !== exp_hdr) $display("FAIL bad_hdr_pulses got %0d exp %0d", hdr_cnt, exp_hdr); else passed++;
    checks++; if (done_cnt !== 2 || stray_done !== 0) $display("FAIL wrap_done got %0d/%0d exp 2/0", done_cnt, stray_done); else passed++;
  endtask

  task automatic test_stall();
    logic [31:0] ws[$];
    int n0;
    clear();
    ws = '{32'hA500_0004, $urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 3; i++) send(ws[i], 0, 0);
    @(negedge clk);
    #2;
    host_valid = 1'b1; host_data = ws[3]; core_busy = 1'b1;
    #1;
    n0 = wr_q.size();
    for (int c = 0; c < 5; c++) begin
      checks++; if (host_ready !== 1'b0) $display("FAIL stall_ready[%0d] got %b exp 0", c, host_ready); else passed++;
      @(negedge clk);
      #2;
    end
    checks++; if (wr_q.size() !== n0) $display("FAIL stall_writes got %0d exp %0d", wr_q.size() - n0, 0); else passed++;
    host_valid = 1'b0; core_busy = 1'b0;
    send(ws[3], 0, 0);
    send(ws[4], 0, 0);
    idle(4);
    model(ws);
    checks++; if (wr_q.size() !== exp_q.size()) $display("FAIL stall_count got %0d exp %0d", wr_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[i].addr !== exp_q[i].addr || wr_q[i].data !== exp_q[i].data || wr_q[i].done !== exp_q[i].done)
        $display("FAIL stall_write[%0d] got a=%0d d=%h last=%b exp a=%0d d=%h last=%b", i,
                 wr_q[i].addr, wr_q[i].data, wr_q[i].done, exp_q[i].addr, exp_q[i].data, exp_q[i].done);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] ws1[$];
    logic [31:0] ws2[$];
    clear();
    ws1 = '{32'hA500_0008, $urandom, $urandom};
    ws2 = '{32'hA510_0001, 32'hDEAD_BEEF};
    foreach (ws1[i]) send(ws1[i], 0, 0);
    @(negedge clk);
    #2;
    host_valid = 1'b0; reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b exp 0", busy); else passed++;
    checks++; if (host_ready !== 1'b0) $display("FAIL rstmid_ready got %b exp 0", host_ready); else passed++;
    checks++; if (mem_wr_en !== 1'b0) $display("FAIL rstmid_wr_en got %b exp 0", mem_wr_en); else passed++;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    foreach (ws2[i]) send(ws2[i], 30, 30);
    idle(4);
    model(ws1);
    model(ws2);
    checks++; if (wr_q.size() !== exp_q.size()) $display("FAIL rstmid_count got %0d exp %0d", wr_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[i].addr !== exp_q[i].addr || wr_q[i].data !== exp_q[i].data || wr_q[i].done !== exp_q[i].done)
        $display("FAIL rstmid_write[%0d] got a=%0d d=%h last=%b exp a=%0d d=%h last=%b", i,
                 wr_q[i].addr, wr_q[i].data, wr_q[i].done, exp_q[i].addr, exp_q[i].data, exp_q[i].done);
      else passed++;
    end
    checks++; if (done_cnt !== 1) $display("FAIL rstmid_done got %0d exp 1", done_cnt); else passed++;
  endtask

  task automatic test_random();
    logic [31:0] ws[$];
    logic [31:0] r;
    logic [7:0]  magic;
    logic [6:0]  cnt;
    int          npay;
    clear();
    for (int t = 0; t < 8; t++) begin
      r = $urandom;
      magic = 8'hA5;
      cnt = 7'($urandom_range(1, 20));
      if (t == 1) cnt = 7'd64;
      if ($urandom_range(3) == 0) begin
        case ($urandom_range(2))
          0: begin magic = 8'($urandom_range(255)); if (magic == 8'hA5) magic = 8'h5A; end
          1: cnt = 7'd0;
          default: cnt = 7'($urandom_range(65, 127));
        endcase
      end
      ws.push_back({magic, r[23:7], cnt});
      npay = (magic == 8'hA5 && cnt >= 1 && cnt <= 64) ? int'(cnt) : 0;
      for (int k = 0; k < npay; k++) ws.push_back($urandom);
    end
    foreach (ws[i]) send(ws[i], 25, 25);
    idle(4);
    model(ws);
    checks++; if (wr_q.size() !== exp_q.size()) $display("FAIL rand_count got %0d exp %0d", wr_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[i].addr !== exp_q[i].addr || wr_q[i].data !== exp_q[i].data || wr_q[i].done !== exp_q[i].done)
        $display("FAIL rand_write[%0d] got a=%0d d=%h last=%b exp a=%0d d=%h last=%b", i,
                 wr_q[i].addr, wr_q[i].data, wr_q[i].done, exp_q[i].addr, exp_q[i].data, exp_q[i].done);
      else passed++;
    end
    checks++; if (hdr_cnt !== exp_hdr) $display("FAIL rand_hdr_err got %0d exp %0d", hdr_cnt, exp_hdr); else passed++;
    checks++; if (stray_done !== 0) $display("FAIL rand_stray_done got %0d exp 0", stray_done); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rand_busy_end got %b exp 0", busy); else passed++;
  endtask

  initial begin
    checks = 0; passed = 0; cyc = 0;
    hdr_cnt = 0; exp_hdr = 0; done_cnt = 0; stray_done = 0; prev_done = 1'b0;
    reset = 1'b0; host_valid = 1'b0; host_data = '0; core_busy = 1'b0;
    #3;
    test_reset();
    test_back_to_back();
    test_wrap_and_bad_header();
    test_stall();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
